// File: rtl/alu_seq16_if.sv
// Bundles the signals between alu_seq16 and the rest of the CPU.
// The slave side is the sequencer. The master side is everything around it:
// the microcode control and the shared 8-bit ALU.
interface alu_seq16_if;
    // Request side (microcode control)
    logic        start;
    logic [3:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        c_in;

    // Status and result
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] y16;
    logic        c_out;
    logic        zero;
    logic        negative;
    logic        overflow;

    // Drive into the shared 8-bit ALU
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_c_in;
    logic        alu_bcd;

    // Results returned by the shared 8-bit ALU
    logic [7:0]  alu_y;
    logic        alu_c_out;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_overflow;

    modport slave (
        input  start, op, a16, b16, c_in,
        input  alu_y, alu_c_out, alu_zero, alu_negative, alu_overflow,
        output busy, done, err, y16, c_out, zero, negative, overflow,
        output alu_a, alu_b, alu_op, alu_c_in, alu_bcd
    );

    modport master (
        output start, op, a16, b16, c_in,
        output alu_y, alu_c_out, alu_zero, alu_negative, alu_overflow,
        input  busy, done, err, y16, c_out, zero, negative, overflow,
        input  alu_a, alu_b, alu_op, alu_c_in, alu_bcd
    );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer.
// Each 16-bit operation is run as two passes through the shared 8-bit ALU.
// Carry and shift bits are chained from pass 1 into pass 2.
// ROR walks from the high byte down. Every other op walks from the low byte up.
// While busy, this block is the only driver of the ALU inputs.
module alu_seq16 (
    input  logic        clk,
    input  logic        reset_b,
    alu_seq16_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_INC = 4'h0;
    localparam logic [3:0] OP_DEC = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_ROR = 4'h4;
    localparam logic [3:0] OP_ASL = 4'h5;
    localparam logic [3:0] OP_ROL = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_EOR = 4'hA;

    state_t      state_q, state_d;

    // Operands latched when a request is accepted
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        cin_q;

    // Pass-1 results, held for use during pass 2
    logic [7:0]  p1_y_q;
    logic        p1_carry_q;
    logic        p1_zero_q;
    logic        p1_neg_q;
    logic        p1_ovf_q;

    // Registered results
    logic [15:0] y16_q;
    logic        c_out_q;
    logic        zero_q;
    logic        neg_q;
    logic        ovf_q;
    logic        err_q;

    // Request decode
    logic        op_legal;
    logic        can_accept;
    logic        accept;
    logic        reject;

    // Per-operation steering, taken from the latched opcode
    logic        hi_first;
    logic        is_logic;

    // ALU drive, before it reaches the bus
    logic        in_pass;
    logic        pass_hi;
    logic [7:0]  drv_a;
    logic [7:0]  drv_b;
    logic [3:0]  drv_op;
    logic        drv_cin;

    // Final-result assembly, used on the edge that enters DONE
    logic [15:0] y16_d;
    logic [1:0]  lane_from_p1;
    logic        c_out_d;
    logic        zero_d;
    logic        neg_d;
    logic        ovf_d;

    // Decode which opcodes the ALU sequencer knows how to split into passes
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_ROR,
            OP_ASL, OP_ROL, OP_OR,  OP_AND, OP_EOR: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    // A request is only looked at when no operation is in flight
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept     = can_accept && bus.start && op_legal;
    assign reject     = can_accept && bus.start && !op_legal;

    assign hi_first = (op_q == OP_ROR);
    assign is_logic = (op_q == OP_OR) || (op_q == OP_AND) || (op_q == OP_EOR);

    // Next-state logic: the two passes always run back to back
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_P1;
            S_P1:    state_d = S_P2;
            S_P2:    state_d = S_DONE;
            S_DONE:  state_d = accept ? S_P1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the operands of an accepted request
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            op_q  <= 4'h0;
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
            cin_q <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.a16;
            b_q   <= bus.b16;
            cin_q <= bus.c_in;
        end
    end

    // Flag a rejected opcode for exactly the cycle after the request
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end

    // Drive the ALU from the state and the latched operands.
    // Outside the passes, the drive is parked at zero.
    always_comb begin
        in_pass = (state_q == S_P1) || (state_q == S_P2);
        pass_hi = 1'b0;
        drv_a   = 8'h00;
        drv_b   = 8'h00;
        drv_op  = 4'h0;
        drv_cin = 1'b0;
        if (in_pass) begin
            // ROR handles the high byte first so that its bit 0 can
            // shift down into bit 7 of the low byte.
            pass_hi = (state_q == S_P1) == hi_first;
            drv_a   = pass_hi ? a_q[15:8] : a_q[7:0];
            drv_b   = pass_hi ? b_q[15:8] : b_q[7:0];
            // The high byte of ASL has to take in the bit that shifted
            // out of the low byte, which is what ROL does.
            drv_op  = ((state_q == S_P2) && (op_q == OP_ASL)) ? OP_ROL : op_q;
            if (is_logic || ((state_q == S_P1) && (op_q == OP_ASL))) begin
                drv_cin = 1'b0;
            end else if (state_q == S_P1) begin
                drv_cin = cin_q;
            end else begin
                drv_cin = p1_carry_q;
            end
        end
    end

    // Capture the pass-1 results so that pass 2 can chain its carry
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            p1_y_q     <= 8'h00;
            p1_carry_q <= 1'b0;
            p1_zero_q  <= 1'b0;
            p1_neg_q   <= 1'b0;
            p1_ovf_q   <= 1'b0;
        end else if (state_q == S_P1) begin
            p1_y_q     <= bus.alu_y;
            p1_carry_q <= bus.alu_c_out;
            p1_zero_q  <= bus.alu_zero;
            p1_neg_q   <= bus.alu_negative;
            p1_ovf_q   <= bus.alu_overflow;
        end
    end

    // Put each result byte back into its lane.
    // Lane 1 is the high byte. It came from pass 1 only for ROR.
    generate
        genvar gi;
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_from_p1[gi]  = (gi == 1) ? hi_first : !hi_first;
            assign y16_d[gi*8 +: 8]  = lane_from_p1[gi] ? p1_y_q : bus.alu_y;
        end
    endgenerate

    // Sign and overflow belong to the high byte, whichever pass produced it
    assign zero_d  = p1_zero_q & bus.alu_zero;
    assign neg_d   = hi_first ? p1_neg_q : bus.alu_negative;
    assign ovf_d   = hi_first ? p1_ovf_q : bus.alu_overflow;
    assign c_out_d = is_logic ? 1'b0 : bus.alu_c_out;

    // Commit the results on the edge that leaves P2 (and enters DONE).
    // They then hold until the next operation completes.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            y16_q   <= 16'h0000;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_P2) begin
            y16_q   <= y16_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = in_pass;
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
    assign bus.y16      = y16_q;
    assign bus.c_out    = c_out_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;

    assign bus.alu_a    = drv_a;
    assign bus.alu_b    = drv_b;
    assign bus.alu_op   = drv_op;
    assign bus.alu_c_in = drv_cin;
    assign bus.alu_bcd  = 1'b0;

endmodule

// File: tb/tb_alu_seq16.sv
// Directed testbench for alu_seq16.
// It contains a small behavioural model of the shared 8-bit ALU.
// The expected 16-bit results below are worked out by hand.
module tb_alu_seq16;

    logic clk;
    logic reset_b;
    int   checks;
    int   errors;

    alu_seq16_if bus();

    alu_seq16 dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU model.
    // SUB computes b - a - !c, and its carry means "no borrow".
    // DEC takes c_in as the borrow-in, and its c_out is the borrow-out.
    // For the logic ops the model drives carry-out high. This makes any
    // leak of that carry onto c_out visible.
    logic [8:0] m_t;
    logic [7:0] m_y;
    logic       m_c;
    logic       m_v;
    always_comb begin
        m_t = 9'h000;
        m_y = 8'h00;
        m_c = 1'b0;
        m_v = 1'b0;
        case (bus.alu_op)
            4'h0: begin m_t = {1'b0, bus.alu_a} + {8'h00, bus.alu_c_in}; m_y = m_t[7:0]; m_c = m_t[8]; end
            4'h1: begin m_t = {1'b0, bus.alu_a} - {8'h00, bus.alu_c_in}; m_y = m_t[7:0]; m_c = m_t[8]; end
            4'h2: begin
                m_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_c_in};
                m_y = m_t[7:0]; m_c = m_t[8];
                m_v = (bus.alu_a[7] == bus.alu_b[7]) && (m_y[7] != bus.alu_a[7]);
            end
            4'h3: begin
                m_t = {1'b0, bus.alu_b} - {1'b0, bus.alu_a} - {8'h00, ~bus.alu_c_in};
                m_y = m_t[7:0]; m_c = ~m_t[8];
            end
            4'h4: begin m_y = {bus.alu_c_in, bus.alu_a[7:1]}; m_c = bus.alu_a[0]; end
            4'h5: begin m_y = {bus.alu_a[6:0], 1'b0};         m_c = bus.alu_a[7]; end
            4'h6: begin m_y = {bus.alu_a[6:0], bus.alu_c_in}; m_c = bus.alu_a[7]; end
            4'h7: begin m_y = bus.alu_a | bus.alu_b; m_c = 1'b1; end
            4'h8: begin m_y = bus.alu_a & bus.alu_b; m_c = 1'b1; end
            4'hA: begin m_y = bus.alu_a ^ bus.alu_b; m_c = 1'b1; end
            default: begin m_y = 8'h00; m_c = 1'b0; end
        endcase
    end
    assign bus.alu_y        = m_y;
    assign bus.alu_c_out    = m_c;
    assign bus.alu_zero     = (m_y == 8'h00);
    assign bus.alu_negative = m_y[7];
    assign bus.alu_overflow = m_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        bus.start = s;
        bus.op    = o;
        bus.a16   = a;
        bus.b16   = b;
        bus.c_in  = c;
    endtask

    task automatic test_reset();
        logic [23:0] got_st;
        logic [21:0] got_alu;
        reset_b = 1'b0;
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        got_st  = {bus.busy, bus.done, bus.err, bus.y16, bus.c_out, bus.zero, bus.negative, bus.overflow, 1'b0};
        got_alu = {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c_in, bus.alu_bcd};
        checks++;
        if (got_st !== 24'h0) begin
            errors++;
            $display("FAIL reset_status got %h want 000000", got_st);
        end
        checks++;
        if (got_alu !== 22'h0) begin
            errors++;
            $display("FAIL reset_alu_drive got %h want 000000", got_alu);
        end
        $display("reset: status=%h alu_drive=%h", got_st, got_alu);
        reset_b = 1'b1;
        tick();
    endtask

    // Table of complete operations, each issued as soon as the previous one reaches DONE
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] y;
        logic        co;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    task automatic test_arith();
        vec_t vecs [10];
        logic [21:0] got, want;
        vecs = '{
            '{4'h2, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0},  // add
            '{4'h0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},  // inc
            '{4'h1, 16'h0100, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0},  // dec
            '{4'h3, 16'h0001, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0},  // sub
            '{4'h6, 16'h8000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0},  // rol
            '{4'h8, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0},  // and
            '{4'h7, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0},  // or
            '{4'hA, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0},  // eor
            '{4'h2, 16'h7F00, 16'h0100, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1},  // add, signed overflow
            '{4'h0, 16'h00FE, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0}   // inc, no carry
        };
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
            tick();
            drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
            checks++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL arith%0d_p1 busy/done got %b want 10", i, {bus.busy, bus.done});
            end
            tick();
            tick();
            got  = {bus.done, bus.busy, bus.y16, bus.c_out, bus.zero, bus.negative, bus.overflow};
            want = {1'b1, 1'b0, vecs[i].y, vecs[i].co, vecs[i].z, vecs[i].n, vecs[i].v};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arith%0d_result got %h want %h", i, got, want);
            end
            $display("op=%h a=%h b=%h c=%b -> y=%h c_out=%b z=%b n=%b v=%b",
                     vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                     bus.y16, bus.c_out, bus.zero, bus.negative, bus.overflow);
        end
        tick();
    endtask

    task automatic test_ror();
        logic [21:0] got;
        drive(1'b1, 4'h4, 16'h0001, 16'h0000, 1'b1);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({bus.alu_a, bus.alu_op, bus.alu_c_in} !== {8'h00, 4'h4, 1'b1}) begin
            errors++;
            $display("FAIL ror_p1_drive got %h/%h/%b want 00/4/1", bus.alu_a, bus.alu_op, bus.alu_c_in);
        end
        tick();
        checks++;
        if ({bus.alu_a, bus.alu_op, bus.alu_c_in} !== {8'h01, 4'h4, 1'b0}) begin
            errors++;
            $display("FAIL ror_p2_drive got %h/%h/%b want 01/4/0", bus.alu_a, bus.alu_op, bus.alu_c_in);
        end
        tick();
        got = {bus.done, bus.busy, bus.y16, bus.c_out, bus.zero, bus.negative, bus.overflow};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h8000, 4'b1010}) begin
            errors++;
            $display("FAIL ror_result got %h want %h", got, {1'b1, 1'b0, 16'h8000, 4'b1010});
        end
        $display("op=4 a=0001 c=1 -> y=%h c_out=%b n=%b", bus.y16, bus.c_out, bus.negative);
        tick();
    endtask

    task automatic test_asl();
        logic [21:0] got;
        drive(1'b1, 4'h5, 16'h8001, 16'h0000, 1'b0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({bus.alu_a, bus.alu_op} !== {8'h01, 4'h5}) begin
            errors++;
            $display("FAIL asl_p1_drive got %h/%h want 01/5", bus.alu_a, bus.alu_op);
        end
        tick();
        checks++;
        if ({bus.alu_a, bus.alu_op, bus.alu_c_in} !== {8'h80, 4'h6, 1'b0}) begin
            errors++;
            $display("FAIL asl_p2_drive got %h/%h/%b want 80/6/0", bus.alu_a, bus.alu_op, bus.alu_c_in);
        end
        tick();
        got = {bus.done, bus.busy, bus.y16, bus.c_out, bus.zero, bus.negative, bus.overflow};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0002, 4'b1000}) begin
            errors++;
            $display("FAIL asl_result got %h want %h", got, {1'b1, 1'b0, 16'h0002, 4'b1000});
        end
        $display("op=5 a=8001 -> y=%h c_out=%b", bus.y16, bus.c_out);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'h2, 16'h0001, 16'h0001, 1'b0);
        tick();
        // A request held during the passes must be ignored
        drive(1'b1, 4'h0, 16'hAAAA, 16'h5555, 1'b1);
        tick();
        tick();
        checks++;
        if ({bus.done, bus.y16} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL b2b_first got done=%b y=%h want done=1 y=0002", bus.done, bus.y16);
        end
        $display("op=2 a=0001 b=0001 -> y=%h (start held while busy)", bus.y16);
        drive(1'b1, 4'h2, 16'h0010, 16'h0020, 1'b0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart busy/done got %b want 10", {bus.busy, bus.done});
        end
        tick();
        tick();
        checks++;
        if ({bus.done, bus.y16} !== {1'b1, 16'h0030}) begin
            errors++;
            $display("FAIL b2b_second got done=%b y=%h want done=1 y=0030", bus.done, bus.y16);
        end
        $display("op=2 a=0010 b=0020 -> y=%h (issued from DONE)", bus.y16);
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.y16} !== {2'b00, 16'h0030}) begin
            errors++;
            $display("FAIL b2b_idle_hold got %b%b y=%h want 00 y=0030", bus.done, bus.busy, bus.y16);
        end
    endtask

    task automatic test_err();
        drive(1'b1, 4'h9, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        checks++;
        if ({bus.err, bus.busy, bus.done, bus.y16} !== {3'b100, 16'h0030}) begin
            errors++;
            $display("FAIL err_op9 got err=%b busy=%b done=%b y=%h want 1 0 0 0030",
                     bus.err, bus.busy, bus.done, bus.y16);
        end
        $display("op=9 -> err=%b busy=%b y=%h", bus.err, bus.busy, bus.y16);
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        tick();
        checks++;
        if ({bus.err, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL err_pulse_end got err=%b busy=%b want 0 0", bus.err, bus.busy);
        end
        // An illegal request arriving in DONE sends the sequencer back to IDLE
        drive(1'b1, 4'h2, 16'h0005, 16'h0003, 1'b0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        drive(1'b1, 4'hF, 16'h1111, 16'h1111, 1'b0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({bus.err, bus.busy, bus.done, bus.y16} !== {3'b100, 16'h0008}) begin
            errors++;
            $display("FAIL err_from_done got err=%b busy=%b done=%b y=%h want 1 0 0 0008",
                     bus.err, bus.busy, bus.done, bus.y16);
        end
        $display("op=F in DONE -> err=%b busy=%b y=%h", bus.err, bus.busy, bus.y16);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [23:0] got_st;
        drive(1'b1, 4'h2, 16'h4000, 16'h0001, 1'b0);
        tick();
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_p2 busy got %b want 1", bus.busy);
        end
        #2;
        reset_b = 1'b0;
        #1;
        got_st = {bus.busy, bus.done, bus.err, bus.y16, bus.c_out, bus.zero, bus.negative,
                  bus.overflow, bus.alu_a};
        checks++;
        if (got_st !== 24'h0) begin
            errors++;
            $display("FAIL rstmid_async got %h want 000000", got_st);
        end
        tick();
        reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.done, bus.busy, bus.y16} !== 18'h0) begin
                errors++;
                $display("FAIL rstmid_after%0d got done=%b busy=%b y=%h want 0 0 0000",
                         i, bus.done, bus.busy, bus.y16);
            end
        end
        $display("reset in P2 -> done=%b busy=%b y=%h", bus.done, bus.busy, bus.y16);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_b = 1'b0;
        drive(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        test_reset();
        test_arith();
        test_ror();
        test_asl();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
